tlb_ptw: RTL and testbench
==========================

Name: tlb_ptw

Overview:
Hardware page-table walker directly downstream of the TLB miss path. It accepts one miss (virtual address) from the TLB's PTW request channel and performs a two-level walk of a 32-bit, 4 KiB-page table through a single-outstanding memory read port. It returns a leaf PTE in the format the TLB consumes: PTE[31:12]=PPN, PTE[1]=W, PTE[0]=R.

Parameters:
PPN_BITS, 20, root page-table PPN width; fixed for the 32-bit address space.
LVL_IDX_BITS, 10, VPN index bits per level.
PTE_BYTES_LOG2, 2, log2 of the PTE size in bytes (4-byte PTEs).

Ports:
clk  input  1  clock
rst  input  1  reset; synchronous, active-low (reset when 0)
ptw_req_valid_i  input  1  walk request valid (from TLB)
ptw_req_ready_o  output  1  walker can accept a request
ptw_vaddr_i  input  32  virtual address to translate
ptw_resp_valid_o  output  1  walk result valid
ptw_resp_ready_i  input  1  TLB accepts the result
ptw_pte_o  output  32  leaf PTE, or 0 on walk fault
satp_ppn_i  input  20  root page-table PPN; sampled at request accept
flush_i  input  1  invalidate walker-internal state (used by the optional feature)
mem_req_valid_o  output  1  memory read request valid
mem_req_ready_i  input  1  memory accepts the request
mem_addr_o  output  32  physical address of the PTE
mem_resp_valid_i  input  1  memory read data valid
mem_resp_ready_o  output  1  walker accepts read data
mem_rdata_i  input  32  PTE read from memory

Behaviour:
- PTE bit meanings: [0]=R, [1]=W, [2]=V (valid), [3]=L (leaf), [11:4] reserved and passed through, [31:12]=PPN.
- States: IDLE, L1_REQ, L1_WAIT, L2_REQ, L2_WAIT, RESP.
- Reset (rst=0 at a clk edge), from any state: go to IDLE. All outputs are 0 (ptw_req_ready_o=0 during reset) and internal registers are cleared. A memory response that is in flight at reset is dropped; the memory side is reset together with the walker.
- IDLE: ptw_req_ready_o=1. When ptw_req_valid_i=1, latch vaddr and satp_ppn_i, then go to L1_REQ.
- L1_REQ: mem_req_valid_o=1, mem_addr_o={satp_ppn, vaddr[31:22], 2'b00}. The address and valid are held stable until mem_req_ready_i=1, then go to L1_WAIT.
- L1_WAIT: mem_resp_ready_o=1. On mem_resp_valid_i, decode the L1 PTE:
  - V=0: ptw_pte_o=0, go to RESP.
  - V=1, L=1 (4 MiB superpage): if PTE[21:12]!=0 (misaligned), fault with ptw_pte_o=0. Otherwise ptw_pte_o={PTE[31:22], vaddr[21:12], PTE[11:0]}. Go to RESP.
  - V=1, L=0: latch next base PTE[31:12], go to L2_REQ.
- L2_REQ: mem_addr_o={base, vaddr[21:12], 2'b00}; same handshake as L1_REQ, then go to L2_WAIT.
- L2_WAIT: on mem_resp_valid_i, if V=1 and L=1 then ptw_pte_o=rdata; otherwise ptw_pte_o=0. Go to RESP.
- RESP: ptw_resp_valid_o=1 with ptw_pte_o held stable. On ptw_resp_ready_i, return to IDLE. ptw_req_ready_o becomes 1 the next cycle; there is no same-cycle re-accept.
- Outputs are registered, and only one walk is outstanding at a time.
- Latency: with zero-wait memory, a two-level walk takes 6 cycles from accept to resp_valid; a superpage or L1 fault takes 4.
- Memory handshakes are AXI-like: the walker never drops mem_req_valid_o before ready, and a response arriving outside a *_WAIT state is not accepted (mem_resp_ready_o=0).
- Without the optional feature, flush_i has no effect.

Optional Feature:
PTW_L1_CACHE_EN: adds a one-entry cache of the last non-leaf L1 PTE, tagged {satp_ppn, vaddr[31:22]}.
- In L1_REQ, a tag hit skips memory and goes directly to L2_REQ using the cached base (hit walk latency drops to 4 cycles).
- The entry is filled on every V=1, L=0 L1 response.
- The entry is invalidated by reset or by flush_i. flush_i takes priority over a simultaneous fill.
- Without the macro: there is no cache, and every walk issues its L1 read.

Decomposition:
- Shared package/header (tlb_ptw_params.vh): state encodings, PTE bit positions (PTE_R, PTE_W, PTE_V, PTE_L), level index widths.
- One natural sub-module, tlb_ptw_pte_decode: combinational PTE classification (invalid / leaf / pointer / misaligned superpage) plus leaf-PTE composition.

Test Plan:
- Two-level walk: satp=0x00010, vaddr=0x00403ABC, L1 read at 0x00010004 returns 0x00020004, L2 read at 0x0002000C returns 0x1234500F -> ptw_pte_o=0x1234500F after 6 cycles.
- Superpage: same vaddr, L1 returns 0x0440000D -> no second read; ptw_pte_o=0x0440300D. L1 returns 0x0440100D (misaligned) -> ptw_pte_o=0.
- Faults: L1 returns 0x00020000 (V=0) -> pte=0, single read. L2 returns 0x12345003 (V=0) -> pte=0.
- Backpressure: mem_req_ready_i low for 3 cycles and ptw_resp_ready_i low for 4 cycles -> mem_addr_o and ptw_pte_o stable throughout, exactly one memory request issued per level.
- Reset asserted (rst=0) in L2_WAIT -> next cycle IDLE with all outputs 0; the next request walks correctly.
- With PTW_L1_CACHE_EN: two walks to vaddr 0x00403ABC then 0x00405000 -> the second issues only the L2 read (0x00020014). After a flush_i pulse, a third walk re-issues the L1 read.

Source files
------------

// File: rtl/tlb_ptw_pkg.sv
// Shared definitions for the two-level page-table walker: geometry, PTE bit
// positions, FSM states and PTE classification codes.
package tlb_ptw_pkg;
    localparam int PPN_BITS       = 20;
    localparam int LVL_IDX_BITS   = 10;
    localparam int PTE_BYTES_LOG2 = 2;
    localparam int VPN_BITS       = 2 * LVL_IDX_BITS;

    localparam int PTE_R = 0;
    localparam int PTE_W = 1;
    localparam int PTE_V = 2;
    localparam int PTE_L = 3;

    typedef enum logic [2:0] {
        S_IDLE, S_L1_REQ, S_L1_WAIT, S_L2_REQ, S_L2_WAIT, S_RESP
    } state_e;

    typedef enum logic [1:0] {
        PTE_INVALID, PTE_LEAF, PTE_PTR, PTE_MISALIGNED
    } pte_kind_e;
endpackage

// File: rtl/tlb_ptw_pte_decode.sv
// Combinational PTE classifier and leaf composer. At level 1 a leaf is a
// 4 MiB superpage whose low PPN bits are replaced by the VPN[0] index.
module tlb_ptw_pte_decode
    import tlb_ptw_pkg::*;
(
    input  logic [31:0]             pte,
    input  logic [LVL_IDX_BITS-1:0] vpn0,
    input  logic                    is_l1,
    output pte_kind_e               kind,
    output logic [31:0]             leaf_pte
);
    always_comb begin
        kind = PTE_LEAF;
        if (!pte[PTE_V])
            kind = PTE_INVALID;
        else if (!pte[PTE_L])
            kind = PTE_PTR;
        else if (is_l1 && pte[21:12] != '0)
            kind = PTE_MISALIGNED;
    end

    assign leaf_pte = is_l1 ? {pte[31:22], vpn0, pte[11:0]} : pte;
endmodule

// File: rtl/tlb_ptw.sv
// Two-level hardware page-table walker with a single-outstanding memory port.
// Optional PTW_L1_CACHE_EN keeps the last non-leaf L1 PTE to skip its read.
module tlb_ptw
    import tlb_ptw_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                ptw_req_valid_i,
    output logic                ptw_req_ready_o,
    input  logic [31:0]         ptw_vaddr_i,
    output logic                ptw_resp_valid_o,
    input  logic                ptw_resp_ready_i,
    output logic [31:0]         ptw_pte_o,
    input  logic [PPN_BITS-1:0] satp_ppn_i,
    input  logic                flush_i,
    output logic                mem_req_valid_o,
    input  logic                mem_req_ready_i,
    output logic [31:0]         mem_addr_o,
    input  logic                mem_resp_valid_i,
    output logic                mem_resp_ready_o,
    input  logic [31:0]         mem_rdata_i
);
    state_e                state, state_nx;
    logic [VPN_BITS-1:0]   vpn_q;
    logic [PPN_BITS-1:0]   satp_q, base_q;
    logic [31:0]           pte_q;
    pte_kind_e             kind;
    logic [31:0]           leaf_pte;
    logic                  cache_hit;
    logic [PPN_BITS-1:0]   cache_base;

    tlb_ptw_pte_decode u_dec (
        .pte      (mem_rdata_i),
        .vpn0     (vpn_q[LVL_IDX_BITS-1:0]),
        .is_l1    (state == S_L1_WAIT),
        .kind     (kind),
        .leaf_pte (leaf_pte)
    );

`ifdef PTW_L1_CACHE_EN
    logic                           cache_vld;
    logic [PPN_BITS+LVL_IDX_BITS-1:0] cache_tag;
    logic                           cache_fill;
    logic                           unused_bits;

    // Hit is evaluated on the incoming request so a hit goes straight to L2.
    assign cache_hit  = cache_vld && !flush_i &&
                        cache_tag == {satp_ppn_i, ptw_vaddr_i[31:22]};
    assign cache_fill = state == S_L1_WAIT && mem_resp_valid_i && kind == PTE_PTR;
    assign unused_bits = ^ptw_vaddr_i[11:0];

    always_ff @(posedge clk) begin
        if (!rst) begin
            cache_vld  <= 1'b0;
            cache_tag  <= '0;
            cache_base <= '0;
        end else if (flush_i) begin
            cache_vld  <= 1'b0;
        end else if (cache_fill) begin
            cache_vld  <= 1'b1;
            cache_tag  <= {satp_q, vpn_q[VPN_BITS-1:LVL_IDX_BITS]};
            cache_base <= mem_rdata_i[31:12];
        end
    end
`else
    logic unused_bits;

    assign cache_hit   = 1'b0;
    assign cache_base  = '0;
    assign unused_bits = ^{ptw_vaddr_i[11:0], flush_i};
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= S_IDLE;
            vpn_q  <= '0;
            satp_q <= '0;
            base_q <= '0;
            pte_q  <= '0;
        end else begin
            state <= state_nx;
            case (state)
                S_IDLE: if (ptw_req_valid_i) begin
                    vpn_q  <= ptw_vaddr_i[31:12];
                    satp_q <= satp_ppn_i;
                    if (cache_hit) base_q <= cache_base;
                end
                S_L1_WAIT: if (mem_resp_valid_i) begin
                    if (kind == PTE_PTR) base_q <= mem_rdata_i[31:12];
                    else pte_q <= (kind == PTE_LEAF) ? leaf_pte : '0;
                end
                // A pointer at the last level is a fault, like an invalid PTE.
                S_L2_WAIT: if (mem_resp_valid_i)
                    pte_q <= (kind == PTE_LEAF) ? leaf_pte : '0;
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nx         = state;
        ptw_req_ready_o  = 1'b0;
        ptw_resp_valid_o = 1'b0;
        mem_req_valid_o  = 1'b0;
        mem_resp_ready_o = 1'b0;
        mem_addr_o       = '0;
        ptw_pte_o        = pte_q;
        case (state)
            S_IDLE: begin
                ptw_req_ready_o = rst;
                if (ptw_req_valid_i) state_nx = cache_hit ? S_L2_REQ : S_L1_REQ;
            end
            S_L1_REQ: begin
                mem_req_valid_o = 1'b1;
                mem_addr_o = {satp_q, vpn_q[VPN_BITS-1:LVL_IDX_BITS], {PTE_BYTES_LOG2{1'b0}}};
                if (mem_req_ready_i) state_nx = S_L1_WAIT;
            end
            S_L1_WAIT: begin
                mem_resp_ready_o = 1'b1;
                if (mem_resp_valid_i) state_nx = (kind == PTE_PTR) ? S_L2_REQ : S_RESP;
            end
            S_L2_REQ: begin
                mem_req_valid_o = 1'b1;
                mem_addr_o = {base_q, vpn_q[LVL_IDX_BITS-1:0], {PTE_BYTES_LOG2{1'b0}}};
                if (mem_req_ready_i) state_nx = S_L2_WAIT;
            end
            S_L2_WAIT: begin
                mem_resp_ready_o = 1'b1;
                if (mem_resp_valid_i) state_nx = S_RESP;
            end
            S_RESP: begin
                ptw_resp_valid_o = 1'b1;
                if (ptw_resp_ready_i) state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_tlb_ptw.sv
// Directed bench for tlb_ptw: a memory responder model plus scoreboard queues
// of expected PTE addresses and expected walk results.
module tb_tlb_ptw;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ptw_req_valid_i = 1'b0;
    logic        ptw_req_ready_o;
    logic [31:0] ptw_vaddr_i = '0;
    logic        ptw_resp_valid_o;
    logic        ptw_resp_ready_i = 1'b0;
    logic [31:0] ptw_pte_o;
    logic [19:0] satp_ppn_i = '0;
    logic        flush_i = 1'b0;
    logic        mem_req_valid_o;
    logic        mem_req_ready_i = 1'b0;
    logic [31:0] mem_addr_o;
    logic        mem_resp_valid_i = 1'b0;
    logic        mem_resp_ready_o;
    logic [31:0] mem_rdata_i = '0;

    tlb_ptw dut (
        .clk(clk), .rst(rst),
        .ptw_req_valid_i(ptw_req_valid_i), .ptw_req_ready_o(ptw_req_ready_o),
        .ptw_vaddr_i(ptw_vaddr_i),
        .ptw_resp_valid_o(ptw_resp_valid_o), .ptw_resp_ready_i(ptw_resp_ready_i),
        .ptw_pte_o(ptw_pte_o), .satp_ppn_i(satp_ppn_i), .flush_i(flush_i),
        .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i),
        .mem_addr_o(mem_addr_o),
        .mem_resp_valid_i(mem_resp_valid_i), .mem_resp_ready_o(mem_resp_ready_o),
        .mem_rdata_i(mem_rdata_i)
    );

    always #5 clk = ~clk;

    localparam logic [19:0] SATP = 20'h00010;

    int          total = 0;
    int          bad = 0;
    logic [31:0] mem [logic [31:0]];
    logic [31:0] addr_q[$];
    logic [31:0] pte_exp_q[$];
    int          req_count = 0;
    int          stall_cfg = 0;
    int          stall_cnt = 0;
    int          hold_from = 1 << 30;

    // responder state
    logic        req_fire = 1'b0;
    logic        resp_fire = 1'b0;
    logic        stalled = 1'b0;
    logic        deliver = 1'b0;
    logic [31:0] last_addr = '0;
    logic [31:0] fire_addr = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Memory model: accepts a request after stall_cnt stalled cycles and returns
    // the read data the cycle after acceptance (zero-wait memory).
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                mem_req_ready_i = 1'b0; mem_resp_valid_i = 1'b0;
                req_fire = 1'b0; resp_fire = 1'b0; stalled = 1'b0;
                hold_from = 1 << 30;
            end else begin
                if (stalled) begin
                    chk("req_held_valid", {31'd0, mem_req_valid_o}, 32'd1);
                    chk("req_held_addr", mem_addr_o, last_addr);
                end
                if (resp_fire) mem_resp_valid_i = 1'b0;
                if (req_fire && deliver) begin
                    mem_resp_valid_i = 1'b1;
                    mem_rdata_i = mem.exists(fire_addr) ? mem[fire_addr] : 32'h0;
                end
                mem_req_ready_i = !(mem_req_valid_o && stall_cnt > 0);
                stalled = mem_req_valid_o && !mem_req_ready_i;
                if (stalled) stall_cnt--;
                last_addr = mem_addr_o;
                req_fire = mem_req_valid_o && mem_req_ready_i;
                if (req_fire) begin
                    chk("mem_req_expected", {31'd0, addr_q.size() != 0}, 32'd1);
                    if (addr_q.size() != 0) chk("mem_addr", mem_addr_o, addr_q.pop_front());
                    deliver = req_count < hold_from;
                    fire_addr = mem_addr_o;
                    req_count++;
                    stall_cnt = stall_cfg;
                end
                resp_fire = mem_resp_valid_i && mem_resp_ready_o;
            end
        end
    end

    task automatic pulse_flush();
        @(negedge clk); flush_i = 1'b1;
        @(negedge clk); flush_i = 1'b0;
    endtask

    task automatic walk(input string tag, input logic [31:0] va, input logic [31:0] exp_pte,
                        input int exp_reads, input int exp_lat, input int rstall, input bit fl);
        int c;
        int base_cnt;
        logic [31:0] exp;
        if (fl) pulse_flush();
        @(negedge clk);
        base_cnt = req_count;
        pte_exp_q.push_back(exp_pte);
        chk({tag, "_req_ready"}, {31'd0, ptw_req_ready_o}, 32'd1);
        ptw_req_valid_i = 1'b1; ptw_vaddr_i = va; satp_ppn_i = SATP;
        @(negedge clk);
        ptw_req_valid_i = 1'b0; ptw_vaddr_i = 32'hFFFF_FFFF; satp_ppn_i = 20'hFFFFF;
        c = 2;
        while (!ptw_resp_valid_o && c < 200) begin @(negedge clk); c++; end
        chk({tag, "_resp_seen"}, {31'd0, ptw_resp_valid_o}, 32'd1);
        if (!ptw_resp_valid_o) begin void'(pte_exp_q.pop_front()); return; end
        chk({tag, "_latency"}, 32'(c), 32'(exp_lat));
        exp = pte_exp_q.pop_front();
        chk({tag, "_pte"}, ptw_pte_o, exp);
        chk({tag, "_busy_not_ready"}, {31'd0, ptw_req_ready_o}, 32'd0);
        for (int i = 0; i < rstall; i++) begin
            @(negedge clk);
            chk({tag, "_stall_valid"}, {31'd0, ptw_resp_valid_o}, 32'd1);
            chk({tag, "_stall_pte"}, ptw_pte_o, exp);
        end
        ptw_resp_ready_i = 1'b1;
        @(negedge clk);
        ptw_resp_ready_i = 1'b0;
        chk({tag, "_resp_done"}, {31'd0, ptw_resp_valid_o}, 32'd0);
        chk({tag, "_ready_again"}, {31'd0, ptw_req_ready_o}, 32'd1);
        chk({tag, "_reads"}, 32'(req_count - base_cnt), 32'(exp_reads));
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_req_ready"}, {31'd0, ptw_req_ready_o}, 32'd0);
        chk({tag, "_resp_valid"}, {31'd0, ptw_resp_valid_o}, 32'd0);
        chk({tag, "_pte"}, ptw_pte_o, 32'd0);
        chk({tag, "_mem_valid"}, {31'd0, mem_req_valid_o}, 32'd0);
        chk({tag, "_mem_addr"}, mem_addr_o, 32'd0);
        chk({tag, "_mem_resp_ready"}, {31'd0, mem_resp_ready_o}, 32'd0);
    endtask

    initial begin
        int c;
        int base_cnt;
        repeat (2) @(negedge clk);
        chk_outputs_zero("reset");
        rst = 1'b1;

        // two-level walk
        mem.delete();
        mem[32'h0001_0004] = 32'h0002_0004;
        mem[32'h0002_000C] = 32'h1234_500F;
        addr_q.push_back(32'h0001_0004); addr_q.push_back(32'h0002_000C);
        walk("two_level", 32'h0040_3ABC, 32'h1234_500F, 2, 6, 0, 1);

        // aligned superpage
        mem[32'h0001_0004] = 32'h0440_000D;
        addr_q.push_back(32'h0001_0004);
        walk("superpage", 32'h0040_3ABC, 32'h0440_300D, 1, 4, 0, 1);

        // misaligned superpage
        mem[32'h0001_0004] = 32'h0440_100D;
        addr_q.push_back(32'h0001_0004);
        walk("misaligned", 32'h0040_3ABC, 32'h0, 1, 4, 0, 1);

        // invalid L1
        mem[32'h0001_0004] = 32'h0002_0000;
        addr_q.push_back(32'h0001_0004);
        walk("l1_invalid", 32'h0040_3ABC, 32'h0, 1, 4, 0, 1);

        // invalid L2
        mem[32'h0001_0004] = 32'h0002_0004;
        mem[32'h0002_000C] = 32'h1234_5003;
        addr_q.push_back(32'h0001_0004); addr_q.push_back(32'h0002_000C);
        walk("l2_invalid", 32'h0040_3ABC, 32'h0, 2, 6, 0, 1);

        // backpressure on both memory requests and on the response
        mem[32'h0002_000C] = 32'h1234_500F;
        stall_cfg = 3; stall_cnt = 3;
        addr_q.push_back(32'h0001_0004); addr_q.push_back(32'h0002_000C);
        walk("backpressure", 32'h0040_3ABC, 32'h1234_500F, 2, 12, 4, 1);
        stall_cfg = 0; stall_cnt = 0;

        // reset while waiting for the L2 response, which never arrives
        pulse_flush();
        @(negedge clk);
        base_cnt = req_count;
        hold_from = req_count + 1;
        addr_q.push_back(32'h0001_0004); addr_q.push_back(32'h0002_000C);
        ptw_req_valid_i = 1'b1; ptw_vaddr_i = 32'h0040_3ABC; satp_ppn_i = SATP;
        @(negedge clk);
        ptw_req_valid_i = 1'b0;
        c = 0;
        while (!(req_count - base_cnt == 2 && mem_resp_ready_o) && c < 50) begin
            @(negedge clk); c++;
        end
        chk("l2_wait_reached", {31'd0, mem_resp_ready_o}, 32'd1);
        rst = 1'b0;
        @(negedge clk);
        chk_outputs_zero("mid_reset");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("post_reset_ready", {31'd0, ptw_req_ready_o}, 32'd1);
        addr_q.delete();
        addr_q.push_back(32'h0001_0004); addr_q.push_back(32'h0002_000C);
        walk("after_reset", 32'h0040_3ABC, 32'h1234_500F, 2, 6, 0, 0);

        // L1 cache reuse, then flush forces the L1 read again
        mem[32'h0002_0014] = 32'h5555_500F;
        addr_q.push_back(32'h0001_0004); addr_q.push_back(32'h0002_000C);
        walk("cache_a", 32'h0040_3ABC, 32'h1234_500F, 2, 6, 0, 1);
`ifdef PTW_L1_CACHE_EN
        addr_q.push_back(32'h0002_0014);
        walk("cache_b", 32'h0040_5000, 32'h5555_500F, 1, 4, 0, 0);
`else
        addr_q.push_back(32'h0001_0004); addr_q.push_back(32'h0002_0014);
        walk("cache_b", 32'h0040_5000, 32'h5555_500F, 2, 6, 0, 0);
`endif
        addr_q.push_back(32'h0001_0004); addr_q.push_back(32'h0002_000C);
        walk("cache_c", 32'h0040_3ABC, 32'h1234_500F, 2, 6, 0, 1);

        chk("addr_queue_drained", 32'(addr_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        bad++;
        $display("FAIL watchdog observed=timeout expected=finish");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end
endmodule
